lcd16x2_bus_sched: RTL and testbench
====================================

Name: lcd16x2_bus_sched

Overview:
- Sequences the HD44780-style 16x2 LCD 8-bit write bus (RS, E, DB[7:0]) at the 125 MHz system clock.
- After reset it runs the power-up init sequence autonomously.
- It then arbitrates two write requesters round-robin and enforces setup, E-pulse, hold and execution-time delays per write.
- It sits between the text/cursor logic in helloworld and the LCD pins.

Parameters:
- POWERUP_CYC, 5000000: wait after reset before the first init write (40 ms at 125 MHz).
- SETUP_CYC, 5: cycles RS/DB are stable before E rises (≥40 ns).
- E_HIGH_CYC, 60: E high width (≥450 ns).
- HOLD_CYC, 3: cycles RS/DB are held after E falls.
- EXEC_SHORT_CYC, 5000: post-write wait for normal commands and data (40 µs).
- EXEC_LONG_CYC, 200000: post-write wait for clear/home (1.6 ms).

Ports:
- clk_i  in  1  system clock, 125 MHz
- rst_ni  in  1  asynchronous active-low reset
- req0_valid_i  in  1  requester 0 has a write pending
- req0_rs_i  in  1  requester 0 RS (0 = command, 1 = data)
- req0_data_i  in  8  requester 0 byte
- req0_ready_o  out  1  requester 0 write accepted this cycle
- req1_valid_i, req1_rs_i, req1_data_i, req1_ready_o: same as requester 0, for requester 1
- init_done_o  out  1  init sequence complete
- busy_o  out  1  bus not idle
- lcd_rs_o  out  1  LCD RS
- lcd_e_o  out  1  LCD enable
- lcd_databus_o  out  8  LCD DB[7:0]

Behaviour:
- Reset, asynchronous on rst_ni low:
  - lcd_e_o=0, lcd_rs_o=0, lcd_databus_o=0x00, both ready=0, init_done_o=0, busy_o=1, state=POWERUP.
  - Assertion mid-write drops E immediately; the whole sequence restarts from POWERUP.
- All pin outputs are registered. Ready outputs are combinational from valid, state and the last-grant flag.
- States:
  - POWERUP: count POWERUP_CYC, then go to INIT_LOAD.
  - INIT_LOAD: latch init ROM[idx] with RS=0, then go to SETUP.
  - IDLE: arbitrate requesters.
  - SETUP: SETUP_CYC cycles, E=0.
  - EHIGH: E_HIGH_CYC cycles, E=1.
  - HOLD: HOLD_CYC cycles, E=0.
  - EXEC: EXEC_SHORT_CYC or EXEC_LONG_CYC cycles, E=0.
  - Leaving EXEC: go to INIT_LOAD if init is incomplete, otherwise IDLE.
- Init ROM, in order: 0x38 (8-bit, 2-line), 0x0C (display on), 0x01 (clear), 0x06 (entry increment).
  - init_done_o rises on the cycle the FSM enters IDLE after the EXEC of the 4th entry.
  - It stays high until reset.
- RS and DB:
  - Driven from the first SETUP cycle.
  - Unchanged through EHIGH, HOLD and EXEC.
  - Keep their last value in IDLE.
- Long exec applies when RS=0 and data[7:1]==0 (0x00–0x03). All other writes use short exec.
- Arbitration, only in IDLE with init_done_o=1:
  - readyN = validN && (!valid_other || last_grant != N).
  - At most one ready is high per cycle.
  - The transfer occurs on the cycle validN && readyN. The FSM goes to SETUP next cycle and last_grant←N.
  - last_grant resets to 1, so requester 0 wins the first tie.
- Requester rules: requesters hold valid, rs and data stable until ready.
  - Valid deasserted before ready: no write, no error.
  - Valid asserted during POWERUP or init: held off, ready=0.
- busy_o = (state != IDLE).
- Latency: accept at cycle N gives:
  - E rise at N+1+SETUP_CYC.
  - E fall at N+1+SETUP_CYC+E_HIGH_CYC.
  - Earliest next accept at N+1+SETUP+E_HIGH+HOLD+EXEC.
- Counter: one shared down-counter, width $clog2(max of all delay parameters)+1, loaded on every state entry. A delay of 0 is treated as 1 cycle.

Decomposition:
- lcd16x2_pkg holds:
  - State encodings.
  - Init ROM contents and length (4).
  - Command constants (CMD_FUNC_8B2L=0x38, CMD_DISP_ON=0x0C, CMD_CLEAR=0x01, CMD_ENTRY_INC=0x06).
  - RS_CMD/RS_DATA.
- Sub-module lcd16x2_rr_arb: 2-way round-robin grant with a last_grant register, combinational grant outputs, and an update strobe.

Test Plan (POWERUP=20, SETUP=2, E_HIGH=4, HOLD=2, EXEC_SHORT=10, EXEC_LONG=30):
- Reset release, no requests:
  - E stays 0 for 20 cycles.
  - Then exactly 4 E pulses, each 4 cycles wide, with DB=0x38, 0x0C, 0x01, 0x06 and RS=0.
  - The gap after 0x01 exceeds 30 cycles.
  - init_done_o rises after the 4th EXEC; busy_o falls with it.
- req0 valid during init with RS=1, DB=0x48:
  - ready0 stays 0 until init_done_o=1, then pulses for one cycle.
  - Next cycle RS=1, DB=0x48; E rises 2 cycles later and is high for 4 cycles.
- Both valid in IDLE (req0 0x48, req1 0x49) held continuously:
  - Grants alternate 0,1,0.
  - E pulses carry 0x48, 0x49, 0x48.
  - Accepts are spaced SETUP+E_HIGH+HOLD+EXEC_SHORT+1 = 19 cycles apart.
- req1 writes a command, RS=0, DB=0x01 → 30-cycle EXEC before the next ready. Command 0x80 → 10-cycle EXEC.
- rst_ni pulsed low while E=1 mid-write:
  - E, RS and DB go to 0 asynchronously; init_done_o=0.
  - After release the full power-up and init sequence repeats.
- valid0 deasserted before grant while valid1 is asserted → req1 is granted; no E pulse for req0.

Source files
------------

// File: rtl/lcd16x2_pkg.sv
// Shared definitions for the HD44780 16x2 write-bus scheduler:
// FSM state encoding, RS polarity, command bytes and the init ROM.
package lcd16x2_pkg;

    typedef enum logic [2:0] {
        ST_POWERUP   = 3'd0,
        ST_INIT_LOAD = 3'd1,
        ST_IDLE      = 3'd2,
        ST_SETUP     = 3'd3,
        ST_EHIGH     = 3'd4,
        ST_HOLD      = 3'd5,
        ST_EXEC      = 3'd6
    } state_e;

    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;

    localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_ENTRY_INC = 8'h06;

    localparam int unsigned INIT_LEN = 4;

    // Power-up command list, issued in index order.
    function automatic logic [7:0] init_rom_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = CMD_FUNC_8B2L;
            2'd1:    b = CMD_DISP_ON;
            2'd2:    b = CMD_CLEAR;
            default: b = CMD_ENTRY_INC;
        endcase
        return b;
    endfunction

    // A zero-length delay still occupies its state for one cycle.
    function automatic int unsigned dly_min1(input int unsigned d);
        return (d == 0) ? 1 : d;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Clear (0x01) and home (0x02/0x03) need the long execution time;
    // 0x00 is grouped with them since it shares the same opcode prefix.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return (rs == RS_CMD) && (data[7:1] == 7'd0);
    endfunction

endpackage

// File: rtl/lcd16x2_rr_arb.sv
// Two-way round-robin arbiter. Grants are combinational; the last-grant
// flag advances only on the update strobe (a completed transfer).
// Handshake: a transfer happens on a cycle where valid && grant are both
// high; requesters hold valid/payload stable until granted and may drop
// valid earlier without side effects.
module lcd16x2_rr_arb
    import lcd16x2_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic update_i,
    output logic grant0_o,
    output logic grant1_o
);

    logic last_q;
    logic last_d;

    // Requester whose turn it is wins a tie; a lone requester always wins.
    always_comb begin
        grant0_o = en_i && valid0_i && (!valid1_i || (last_q != 1'b0));
        grant1_o = en_i && valid1_i && (!valid0_i || (last_q != 1'b1));
        last_d   = update_i ? grant1_o : last_q;
    end

    // Last-grant register; resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/lcd16x2_bus_sched.sv
// HD44780 16x2 8-bit write-bus scheduler. Runs the power-up init list,
// then serves two requesters round-robin, timing setup / E-pulse / hold /
// execution for every write with a single shared down-counter.
module lcd16x2_bus_sched
    import lcd16x2_pkg::*;
#(
    parameter int unsigned POWERUP_CYC    = 5000000,
    parameter int unsigned SETUP_CYC      = 5,
    parameter int unsigned E_HIGH_CYC     = 60,
    parameter int unsigned HOLD_CYC       = 3,
    parameter int unsigned EXEC_SHORT_CYC = 5000,
    parameter int unsigned EXEC_LONG_CYC  = 200000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req0_valid_i,
    input  logic       req0_rs_i,
    input  logic [7:0] req0_data_i,
    output logic       req0_ready_o,
    input  logic       req1_valid_i,
    input  logic       req1_rs_i,
    input  logic [7:0] req1_data_i,
    output logic       req1_ready_o,
    output logic       init_done_o,
    output logic       busy_o,
    output logic       lcd_rs_o,
    output logic       lcd_e_o,
    output logic [7:0] lcd_databus_o
);

    localparam int unsigned MAX_DLY = max2(max2(max2(POWERUP_CYC, SETUP_CYC),
                                                max2(E_HIGH_CYC, HOLD_CYC)),
                                           max2(EXEC_SHORT_CYC, EXEC_LONG_CYC));
    localparam int unsigned CNT_W   = $clog2(MAX_DLY) + 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic               init_done_q, init_done_d;
    logic               rs_q, rs_d;
    logic [7:0]         db_q, db_d;
    logic               e_q, e_d;
    logic               gnt0, gnt1;
    logic               accept;
    logic               cnt_expired;

    // Dwell time for the state being entered; EXEC length depends on the
    // byte already on the bus.
    function automatic logic [CNT_W-1:0] load_for(input state_e s, input logic rs,
                                                  input logic [7:0] db);
        logic [CNT_W-1:0] v;
        case (s)
            ST_POWERUP: v = CNT_W'(dly_min1(POWERUP_CYC));
            ST_SETUP:   v = CNT_W'(dly_min1(SETUP_CYC));
            ST_EHIGH:   v = CNT_W'(dly_min1(E_HIGH_CYC));
            ST_HOLD:    v = CNT_W'(dly_min1(HOLD_CYC));
            ST_EXEC:    v = is_long_cmd(rs, db) ? CNT_W'(dly_min1(EXEC_LONG_CYC))
                                                : CNT_W'(dly_min1(EXEC_SHORT_CYC));
            default:    v = CNT_W'(1);
        endcase
        return v;
    endfunction

    lcd16x2_rr_arb u_arb (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .en_i     ((state_q == ST_IDLE) && init_done_q),
        .valid0_i (req0_valid_i),
        .valid1_i (req1_valid_i),
        .update_i (accept),
        .grant0_o (gnt0),
        .grant1_o (gnt1)
    );

    assign accept       = gnt0 | gnt1;
    assign cnt_expired  = (cnt_q <= CNT_W'(1));
    assign req0_ready_o = gnt0;
    assign req1_ready_o = gnt1;
    assign busy_o       = (state_q != ST_IDLE);
    assign init_done_o  = init_done_q;
    assign lcd_rs_o     = rs_q;
    assign lcd_e_o      = e_q;
    assign lcd_databus_o = db_q;

    // Next-state, counter and bus-pin logic; pins are computed from the
    // next state so the registered outputs line up with the state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        init_done_d = init_done_q;
        rs_d        = rs_q;
        db_d        = db_q;

        case (state_q)
            ST_POWERUP: begin
                if (cnt_expired) state_d = ST_INIT_LOAD;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_INIT_LOAD: begin
                state_d = ST_SETUP;
                rs_d    = RS_CMD;
                db_d    = init_rom_byte(idx_q);
            end
            ST_IDLE: begin
                if (gnt0) begin
                    state_d = ST_SETUP;
                    rs_d    = req0_rs_i;
                    db_d    = req0_data_i;
                end else if (gnt1) begin
                    state_d = ST_SETUP;
                    rs_d    = req1_rs_i;
                    db_d    = req1_data_i;
                end
            end
            ST_SETUP: begin
                if (cnt_expired) state_d = ST_EHIGH;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_EHIGH: begin
                if (cnt_expired) state_d = ST_HOLD;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_HOLD: begin
                if (cnt_expired) state_d = ST_EXEC;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_EXEC: begin
                if (cnt_expired) begin
                    if (init_done_q) begin
                        state_d = ST_IDLE;
                    end else if (idx_q == 2'(INIT_LEN - 1)) begin
                        state_d     = ST_IDLE;
                        init_done_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_INIT_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_POWERUP;
        endcase

        // Every transition changes state, so a change marks a state entry.
        if (state_d != state_q) cnt_d = load_for(state_d, rs_d, db_d);

        e_d = (state_d == ST_EHIGH);
    end

    // State, counter and pin registers; reset drops E at once and restarts
    // the whole power-up sequence.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_POWERUP;
            cnt_q       <= CNT_W'(dly_min1(POWERUP_CYC));
            idx_q       <= 2'd0;
            init_done_q <= 1'b0;
            rs_q        <= 1'b0;
            db_q        <= 8'h00;
            e_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
            rs_q        <= rs_d;
            db_q        <= db_d;
            e_q         <= e_d;
        end
    end

endmodule

// File: tb/tb_lcd16x2_bus_sched.sv
// Directed bench for lcd16x2_bus_sched with short delays
// (POWERUP=20, SETUP=2, E_HIGH=4, HOLD=2, EXEC_SHORT=10, EXEC_LONG=30).
module tb_lcd16x2_bus_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_rs, req0_ready;
    logic [7:0] req0_data;
    logic       req1_valid, req1_rs, req1_ready;
    logic [7:0] req1_data;
    logic       init_done, busy, lcd_rs, lcd_e;
    logic [7:0] lcd_db;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    logic [31:0] exp_q[$];   // expected {rs, db} of each E pulse, in order
    int          rise_q[$];  // cycle of each E rise
    int          acc_who[$]; // requester id of each accepted write
    int          acc_cyc[$]; // cycle of each accepted write

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    lcd16x2_bus_sched #(
        .POWERUP_CYC    (20),
        .SETUP_CYC      (2),
        .E_HIGH_CYC     (4),
        .HOLD_CYC       (2),
        .EXEC_SHORT_CYC (10),
        .EXEC_LONG_CYC  (30)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req0_valid_i  (req0_valid),
        .req0_rs_i     (req0_rs),
        .req0_data_i   (req0_data),
        .req0_ready_o  (req0_ready),
        .req1_valid_i  (req1_valid),
        .req1_rs_i     (req1_rs),
        .req1_data_i   (req1_data),
        .req1_ready_o  (req1_ready),
        .init_done_o   (init_done),
        .busy_o        (busy),
        .lcd_rs_o      (lcd_rs),
        .lcd_e_o       (lcd_e),
        .lcd_databus_o (lcd_db)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t cyc=%0d)", tag, got, exp, $time, cyc);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic prev_e = 1'b0;
    int   rise_start = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_e = 1'b0;
        end else begin
            if (req0_valid && req0_ready) begin
                acc_who.push_back(0);
                acc_cyc.push_back(cyc);
            end
            if (req1_valid && req1_ready) begin
                acc_who.push_back(1);
                acc_cyc.push_back(cyc);
            end
            if (lcd_e && !prev_e) begin
                logic [31:0] exp_v;
                exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
                rise_q.push_back(cyc);
                rise_start = cyc;
                check("pulse_rs_db", {23'd0, lcd_rs, lcd_db}, exp_v);
            end
            if (!lcd_e && prev_e) check("e_width", cyc - rise_start, 4);
            prev_e = lcd_e;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_init_exp();
        exp_q.push_back(32'h038);
        exp_q.push_back(32'h00C);
        exp_q.push_back(32'h001);
        exp_q.push_back(32'h006);
    endtask

    task automatic wait_acc(input int n, input int budget, input string tag);
        for (int t = 0; t < budget && acc_who.size() < n; t++) @(negedge clk);
        check(tag, acc_who.size(), n);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        for (int t = 0; t < budget && busy; t++) @(negedge clk);
        check(tag, busy, 0);
    endtask

    task automatic check_init_rises();
        check("init_rise0", rise_q.size() > 0 ? rise_q[0] : -1, 23);
        check("init_rise1", rise_q.size() > 1 ? rise_q[1] : -1, 42);
        check("init_rise2", rise_q.size() > 2 ? rise_q[2] : -1, 61);
        check("init_rise3", rise_q.size() > 3 ? rise_q[3] : -1, 100);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int first_done;
        int busy_115;
        int bad_ready;
        int first_ready;

        rst_n      = 1'b0;
        req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h11;
        req1_valid = 1'b1; req1_rs = 1'b1; req1_data = 8'h22;
        push_init_exp();
        repeat (3) @(negedge clk);

        // reset state, with both requesters pushing
        check("rst_e", lcd_e, 0);
        check("rst_rs", lcd_rs, 0);
        check("rst_db", lcd_db, 0);
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_init_done", init_done, 0);
        check("rst_busy", busy, 1);

        // power-up and init with no requests
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;
        first_done = -1;
        busy_115 = -1;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (cyc == 115) busy_115 = busy;
            if (init_done) begin
                first_done = cyc;
                break;
            end
        end
        check("init_done_cyc", first_done, 116);
        check("busy_before_done", busy_115, 1);
        check("busy_at_done", busy, 0);
        check("init_pulse_count", rise_q.size(), 4);
        check_init_rises();

        // both requesters held: grants alternate 0,1,0
        rise_q.delete(); acc_who.delete(); acc_cyc.delete();
        exp_q.push_back(32'h148);
        exp_q.push_back(32'h149);
        exp_q.push_back(32'h148);
        req0_rs = 1'b1; req0_data = 8'h48; req0_valid = 1'b1;
        req1_rs = 1'b1; req1_data = 8'h49; req1_valid = 1'b1;
        wait_acc(3, 100, "rr_accepts");
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("rr_who0", acc_who.size() > 0 ? acc_who[0] : -1, 0);
        check("rr_who1", acc_who.size() > 1 ? acc_who[1] : -1, 1);
        check("rr_who2", acc_who.size() > 2 ? acc_who[2] : -1, 0);
        check("rr_gap01", acc_cyc.size() > 1 ? acc_cyc[1] - acc_cyc[0] : -1, 19);
        check("rr_gap12", acc_cyc.size() > 2 ? acc_cyc[2] - acc_cyc[1] : -1, 19);
        check("e_rise_latency", (rise_q.size() > 0 && acc_cyc.size() > 0) ?
                                rise_q[0] - acc_cyc[0] : -1, 3);

        // req1 commands: clear gets long exec, 0x80 gets short exec
        wait_idle(100, "idle_before_cmd");
        rise_q.delete(); acc_who.delete(); acc_cyc.delete();
        exp_q.push_back(32'h001);
        req1_rs = 1'b0; req1_data = 8'h01; req1_valid = 1'b1;
        wait_acc(1, 100, "cmd_clear_accept");
        @(posedge clk); #1;
        exp_q.push_back(32'h080);
        req1_data = 8'h80;
        wait_acc(2, 100, "cmd_80_accept");
        @(posedge clk); #1;
        exp_q.push_back(32'h141);
        req1_rs = 1'b1; req1_data = 8'h41;
        wait_acc(3, 100, "data_41_accept");
        @(posedge clk); #1;
        req1_valid = 1'b0;
        check("long_exec_gap", acc_cyc.size() > 1 ? acc_cyc[1] - acc_cyc[0] : -1, 39);
        check("short_exec_gap", acc_cyc.size() > 2 ? acc_cyc[2] - acc_cyc[1] : -1, 19);

        // req0 withdraws while busy; req1 must be the one served
        exp_q.push_back(32'h14A);
        req0_rs = 1'b1; req0_data = 8'h55; req0_valid = 1'b1;
        req1_rs = 1'b1; req1_data = 8'h4A; req1_valid = 1'b1;
        repeat (5) @(negedge clk);
        req0_valid = 1'b0;
        wait_acc(4, 100, "withdraw_accept");
        @(posedge clk); #1;
        req1_valid = 1'b0;
        repeat (30) @(negedge clk);
        check("withdraw_who", acc_who.size() > 3 ? acc_who[3] : -1, 1);
        check("withdraw_pulses", rise_q.size(), 4);
        check("exp_drained", exp_q.size(), 0);

        // reset in the middle of an E pulse
        wait_idle(100, "idle_before_abort");
        exp_q.push_back(32'h133);
        req0_rs = 1'b1; req0_data = 8'h33; req0_valid = 1'b1;
        for (int t = 0; t < 50 && !lcd_e; t++) @(negedge clk);
        check("abort_e_seen", lcd_e, 1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_e", lcd_e, 0);
        check("abort_rs", lcd_rs, 0);
        check("abort_db", lcd_db, 0);
        check("abort_init_done", init_done, 0);
        check("abort_busy", busy, 1);

        // re-init with req0 already waiting
        rise_q.delete(); acc_who.delete(); acc_cyc.delete();
        exp_q.delete();
        push_init_exp();
        exp_q.push_back(32'h148);
        req0_rs = 1'b1; req0_data = 8'h48; req0_valid = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad_ready = 0;
        first_ready = -1;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (req0_ready && !init_done) bad_ready++;
            if (req0_ready) begin
                first_ready = cyc;
                break;
            end
        end
        check("ready0_held_off", bad_ready, 0);
        check("ready0_first_cyc", first_ready, 116);
        @(negedge clk);
        check("post_accept_ready0", req0_ready, 0);
        check("post_accept_rs", lcd_rs, 1);
        check("post_accept_db", lcd_db, 8'h48);
        check("post_accept_e", lcd_e, 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        repeat (30) @(negedge clk);
        check_init_rises();
        check("req0_rise", rise_q.size() > 4 ? rise_q[4] : -1, 119);
        check("final_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
